// File: rtl/alu_pkg.sv
// Shared ALU datapath types: accumulator FSM states, default widths, saturation bounds.
package alu_pkg;

  typedef enum logic [1:0] {ACC_IDLE, ACC_ACCUM, ACC_HOLD} acc_state_t;

  localparam int ACC_DEF_WIDTH = 24;
  localparam int LEN_DEF_WIDTH = 8;

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// Combinational signed add of a sign-extended operand into an accumulator.
// On overflow the result clamps to the accumulator's signed range and o_ovf is raised.
module sat_adder
  import alu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_add,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  localparam logic signed [63:0] MAXV = sat_max(ACC_W);
  localparam logic signed [63:0] MINV = sat_min(ACC_W);

  // One guard bit: overflow shows up as a disagreement between the top two sum bits.
  logic [ACC_W:0] w_sum;

  assign w_sum = {i_acc[ACC_W-1], i_acc} + {{(ACC_W + 1 - IN_W){i_add[IN_W-1]}}, i_add};
  assign o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (o_ovf) begin
      o_sum = w_sum[ACC_W] ? MINV[ACC_W-1:0] : MAXV[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Sums a run of signed products into a saturating dot-product result, shown on valid/ready.
// Result is valid one cycle after the last product is taken and held until out_ready.
module mac_accumulator
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + 8,
  parameter int LEN_WIDTH = LEN_DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] run_len,
  input  logic                 mul_valid,
  input  logic [2*WIDTH-1:0]   mul2acc,
  output logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc2out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag,
  output logic                 busy
);

  localparam logic [LEN_WIDTH:0] REM_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  acc_state_t           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH:0]   r_rem;
  logic                 r_sat;
  logic                 r_acc_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_ovf;

  sat_adder #(
    .IN_W  (2 * WIDTH),
    .ACC_W (ACC_WIDTH)
  ) u_sat_adder (
    .i_acc (r_acc),
    .i_add (mul2acc),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC_IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_sat       <= 1'b0;
      r_acc_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ACC_IDLE: begin
          if (start) begin
            r_state     <= ACC_ACCUM;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_rem       <= (run_len == '0) ? REM_ONE : {1'b0, run_len};
            r_acc_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ACC_ACCUM: begin
          if (mul_valid && r_acc_ready) begin
            r_acc <= w_sum;
            r_sat <= r_sat | w_ovf;
            r_rem <= r_rem - REM_ONE;
            if (r_rem == REM_ONE) begin
              r_state     <= ACC_HOLD;
              r_acc_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ACC_HOLD: begin
          if (out_ready) begin
            r_state     <= ACC_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ACC_IDLE;
          r_acc_ready <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_ready = r_acc_ready;
  assign acc2out   = r_acc;
  assign out_valid = r_out_valid;
  assign sat_flag  = r_sat;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator with a 16-bit accumulator so saturation is reachable.
module tb_mac_accumulator;

  localparam int W  = 8;
  localparam int AW = 16;
  localparam int LW = 8;
  localparam int AMAX = 32767;
  localparam int AMIN = -32768;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] run_len;
  logic          mul_valid;
  logic [2*W-1:0] mul2acc;
  logic          acc_ready;
  logic [AW-1:0] acc2out;
  logic          out_valid;
  logic          out_ready;
  logic          sat_flag;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_results = 0;

  int exp_acc_q[$];
  int exp_sat_q[$];

  int m_acc;
  int m_sat;
  int m_rem;

  mac_accumulator #(
    .WIDTH     (W),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run_len   (run_len),
    .mul_valid (mul_valid),
    .mul2acc   (mul2acc),
    .acc_ready (acc_ready),
    .acc2out   (acc2out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int acc_s();
    return int'($signed(acc2out));
  endfunction

  // Result monitor: every completed output handshake is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (exp_acc_q.size() == 0) begin
        chk("sb_unexpected_result", acc_s(), 0);
      end else begin
        chk("sb_acc2out", acc_s(), exp_acc_q.pop_front());
        chk("sb_sat_flag", int'(sat_flag), exp_sat_q.pop_front());
      end
    end
  end

  task automatic start_run(input int len);
    start   = 1'b1;
    run_len = LW'(len);
    m_acc   = 0;
    m_sat   = 0;
    m_rem   = (len == 0) ? 1 : len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Presents one product and holds it until the accumulator takes it.
  task automatic send(input int prod);
    bit taken = 0;
    mul_valid = 1'b1;
    mul2acc   = (2*W)'(prod);
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (acc_ready) taken = 1;
      @(posedge clk);
      #1;
    end
    mul_valid = 1'b0;
    if (!taken) chk("send_timeout", 0, 1);
    m_acc = m_acc + prod;
    if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1; end
    if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1; end
    m_rem--;
    if (m_rem == 0) begin
      exp_acc_q.push_back(m_acc);
      exp_sat_q.push_back(m_sat);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) chk(tag, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    run_len   = '0;
    mul_valid = 1'b0;
    mul2acc   = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_acc_ready", int'(acc_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_acc2out", acc_s(), 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: asynchronous reset in the middle of a run, checked before any clock edge
    start_run(3);
    send(-40);
    chk("t1_pre_acc", acc_s(), -40);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_acc_ready", int'(acc_ready), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_acc2out", acc_s(), 0);
    chk("t1_out_valid", int'(out_valid), 0);
    chk("t1_sat_flag", int'(sat_flag), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T2: plain dot product, result one cycle after the last product
    start_run(3);
    @(negedge clk);
    chk("t2_first_ready", int'(acc_ready), 1);
    @(posedge clk);
    #1;
    send(-40);
    send(21);
    send(-128);
    @(negedge clk);
    chk("t2_latency", int'(out_valid), 1);
    wait_idle("t2_idle_timeout");

    // T3: stalls between products, then output backpressure
    start_run(2);
    send(100);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(50);
    for (int i = 0; i < 5; i++) begin
      mul_valid = 1'b1;
      mul2acc   = 16'd7;
      @(negedge clk);
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_acc", acc_s(), 150);
      chk("t3_hold_ready", int'(acc_ready), 0);
      @(posedge clk);
      #1;
    end
    mul_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("t3_idle_timeout");

    // T4: positive and negative saturation
    start_run(4);
    for (int i = 0; i < 4; i++) send(16384);
    wait_idle("t4p_idle_timeout");
    start_run(4);
    for (int i = 0; i < 4; i++) send(-16384);
    wait_idle("t4n_idle_timeout");

    // T5: zero run length behaves as one product
    start_run(0);
    send(64);
    @(negedge clk);
    chk("t5_one_product", int'(out_valid), 1);
    wait_idle("t5_idle_timeout");

    // T6: start ignored in ACCUM and HOLD, then back-to-back runs
    start_run(2);
    send(10);
    start   = 1'b1;
    run_len = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    out_ready = 1'b0;
    send(20);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t6_hold_busy", int'(busy), 1);
    chk("t6_hold_valid", int'(out_valid), 1);
    chk("t6_hold_acc", acc_s(), 30);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    start_run(1);
    @(negedge clk);
    chk("t6_b2b_clear", acc_s(), 0);
    chk("t6_b2b_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    send(5);
    wait_idle("t6_idle_timeout");
    @(negedge clk);
    chk("t6_acc_kept", acc_s(), 5);

    chk("sb_leftover", exp_acc_q.size(), 0);
    chk("sb_result_count", n_results, 7);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
